alu_exec_ctrl: RTL
==================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 8..64.
REQ-002 Parameter MULDIV_EN, default 1, enables multi-cycle multiply/divide; when 0, those functs decode as illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 alu_op  input  2  main-decoder class: 00 add, 01 sub, 10 funct-decoded, 11 reserved.
REQ-008 funct  input  6  instruction funct/opcode field, used when alu_op=10.
REQ-009 a, b  input  WIDTH  operands, unsigned except for slt.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  primary result (lo word / quotient).
REQ-013 result_hi  output  WIDTH  high product word / remainder; 0 for single-cycle ops.
REQ-014 op  output  4  latched ALU control code of the accepted request (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1000 mult, 1001 divu, 1111 illegal).
REQ-015 zero  output  1  result == 0.
REQ-016 illegal  output  1  accepted request did not decode.

Function
REQ-017 Decode: alu_op 00 -> add; 01 -> sub; 10 with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed), 001100 and, 001101 or, 011000 mult (unsigned), 011011 divu; any other funct or alu_op=11 -> illegal.
REQ-018 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 Request accepted on the edge where in_valid && in_ready; a, b, decoded op latched on that edge.
REQ-020 Single-cycle ops (add/sub/and/or/slt/illegal): IDLE -> DONE on accept; out_valid asserted the following cycle (latency 1).
REQ-021 mult/divu: IDLE -> CALC on accept; iterative shift-add / restoring divide, one bit per cycle, exactly WIDTH CALC cycles, then DONE; out_valid latency WIDTH+1.
REQ-022 add/sub wrap modulo 2^WIDTH, no overflow flag; slt result is 1 or 0 zero-extended.
REQ-023 mult: {result_hi, result} = full 2*WIDTH-bit unsigned product.
REQ-024 divu by zero: result = all ones, result_hi = a; no early termination, latency unchanged.
REQ-025 Illegal: result = 0, result_hi = 0, illegal = 1, op = 1111.
REQ-026 DONE holds result, result_hi, op, zero, illegal stable while out_valid && !out_ready.
REQ-027 DONE -> IDLE on out_valid && out_ready; out_valid drops the next cycle; no new accept on that same edge.
REQ-028 in_valid and inputs ignored outside IDLE; operand changes during CALC do not affect the result.
REQ-029 zero computed from the final result only (lo word for mult).

Reset
REQ-030 rst_n low at an edge forces IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, op=0000, zero=1, illegal=0, iteration counter=0.
REQ-031 Reset mid-CALC or mid-DONE aborts the operation; no out_valid is produced for it.

Structure
REQ-032 Op-code constants (4-bit ALU codes), funct encodings and FSM state encodings SHALL live in shared package alu_pkg.
REQ-033 Iterative multiply/divide datapath SHALL be one sub-module, muldiv_iter (start, is_div, a, b, done, hi, lo), instantiated only when MULDIV_EN=1.

Verification
REQ-034 alu_op=10, funct=100010, a=5, b=7, out_ready=1 -> one cycle later out_valid=1, result=0xFFFFFFFE, op=0110, zero=0.
REQ-035 alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1; a=1, b=0xFFFFFFFF -> result=0, zero=1.
REQ-036 funct=011000, a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept, result_hi=1, result=0xFFFFFFFE, op=1000.
REQ-037 funct=011011, a=100, b=0 -> result=0xFFFFFFFF, result_hi=100; then a=100, b=7 -> result=14, result_hi=2.
REQ-038 alu_op=11 -> illegal=1, op=1111, result=0; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-039 rst_n low at CALC cycle 10 of a mult -> next cycle IDLE, in_ready=1, out_valid never asserts for that request.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, funct encodings, FSM states and the main decoder
// for the ALU execute controller.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_MULT = 4'b1000,
    ALU_DIVU = 4'b1001,
    ALU_ILL  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_ANDI  = 6'b001100;
  localparam logic [5:0] F_ORI   = 6'b001101;
  localparam logic [5:0] F_MULTU = 6'b011000;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Multiply/divide only decode when the iterative unit is built.
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                           input logic [5:0] funct,
                                           input logic       muldiv_en);
    alu_ctrl_e c;
    c = ALU_ILL;
    case (alu_op)
      AOP_ADD: c = ALU_ADD;
      AOP_SUB: c = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          F_ADD:          c = ALU_ADD;
          F_SUB:          c = ALU_SUB;
          F_AND, F_ANDI:  c = ALU_AND;
          F_OR, F_ORI:    c = ALU_OR;
          F_SLT:          c = ALU_SLT;
          F_MULTU:        c = muldiv_en ? ALU_MULT : ALU_ILL;
          F_DIVU:         c = muldiv_en ? ALU_DIVU : ALU_ILL;
          default:        c = ALU_ILL;
        endcase
      end
      default: c = ALU_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle; the first step runs on the start edge so results are ready after WIDTH edges.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] m_q;

  // Multiply: {hi,lo} holds {partial, multiplier}. Divide: {hi,lo} holds
  // {remainder, dividend/quotient}. A zero divisor naturally yields all-ones/a.
  function automatic logic [2*WIDTH-1:0] md_step(input logic             div,
                                                 input logic [WIDTH-1:0] h,
                                                 input logic [WIDTH-1:0] l,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    logic [2*WIDTH-1:0] r;
    sum   = {1'b0, h} + (l[0] ? {1'b0, m} : '0);
    sh    = {h, l[WIDTH-1]};
    trial = sh - {1'b0, m};
    if (!div)
      r = {sum[WIDTH:1], sum[0], l[WIDTH-1:1]};
    else if (sh >= {1'b0, m})
      r = {trial[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
    else
      r = {sh[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q       <= 1'b1;
      div_q        <= is_div;
      m_q          <= b;
      cnt_q        <= CNT_W'(1);
      {hi_q, lo_q} <= md_step(is_div, '0, a, b);
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(WIDTH)) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q        <= cnt_q + CNT_W'(1);
        {hi_q, lo_q} <= md_step(div_q, hi_q, lo_q, m_q);
      end
    end
  end

  assign done = busy_q && (cnt_q == CNT_W'(WIDTH));
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU execute controller: decodes alu_op/funct, runs single-cycle ops directly
// and mult/divu through the iterative unit, with a valid/ready handshake.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       op,
  output logic             zero,
  output logic             illegal
);

  state_e           state_q;
  alu_ctrl_e        op_q;
  alu_ctrl_e        dec_op;
  logic             dec_md;
  logic [WIDTH-1:0] alu_res;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  function automatic logic [WIDTH-1:0] alu_calc(input alu_ctrl_e        c,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (c)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign dec_op   = alu_decode(alu_op, funct, MULDIV_EN);
  assign dec_md   = (dec_op == ALU_MULT) || (dec_op == ALU_DIVU);
  assign alu_res  = alu_calc(dec_op, a, b);
  assign md_start = (state_q == ST_IDLE) && in_valid && dec_md;

  generate
    if (MULDIV_EN) begin : g_muldiv
      muldiv_iter #(
        .WIDTH (WIDTH)
      ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (dec_op == ALU_DIVU),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
      );
    end else begin : g_no_muldiv
      assign md_done = 1'b0;
      assign md_hi   = '0;
      assign md_lo   = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      op_q      <= ALU_AND;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= dec_op;
            illegal  <= (dec_op == ALU_ILL);
            in_ready <= 1'b0;
            if (dec_md) begin
              state_q <= ST_CALC;
            end else begin
              state_q   <= ST_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              result_hi <= '0;
              zero      <= (alu_res == '0);
            end
          end
        end
        ST_CALC: begin
          if (md_done) begin
            state_q   <= ST_DONE;
            out_valid <= 1'b1;
            result    <= md_lo;
            result_hi <= md_hi;
            zero      <= (md_lo == '0);
          end
        end
        ST_DONE: begin
          // Return to IDLE only; a new request waits for the following edge.
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign op = op_q;

endmodule
